// File: rtl/router_pkg.sv
// router_pkg: shared types for the 1x3 router packet controller.
// State enum, address constants and a one-hot port decode helper.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [3:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR,
    DROP
  } state_e;

  function automatic logic [NUM_PORTS-1:0] port_onehot(
    input logic [1:0] a
  );
    logic [NUM_PORTS-1:0] v;
    v = '0;
    case (a)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// router_wait_timer: counts consecutive WAIT_TILL_EMPTY cycles.
// expired flags the last allowed cycle (count == WAIT_LIMIT-1).
module router_wait_timer
  import router_pkg::*;
#(
  parameter int WAIT_LIMIT = 64
)
(
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(WAIT_LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  assign expired = en && (cnt == CW'(WAIT_LIMIT - 1));

endmodule

// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing controller for the 1x3 router.
// WTE timeout/drop path is enabled by defining ROUTER_FSM_TIMEOUT_EN.
module router_fsm
  import router_pkg::*;
#(
  parameter int WAIT_LIMIT = 64
)
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_vld,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  input  logic       parity_done,
  input  logic       low_pkt_vld,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy,
  output logic [2:0] dest_sel,
  output logic       drop_pkt
);

  state_e     st;
  state_e     nxt;
  logic [1:0] addr_q;

  logic hdr_ok;
  logic hdr_empty;
  logic sel_empty;
  logic sel_srst;
  logic wait_expired;

  assign hdr_ok    = pkt_vld && (data_in != ADDR_INVALID);
  assign hdr_empty = |(fifo_empty & port_onehot(data_in));
  assign sel_empty = |(fifo_empty & port_onehot(addr_q));
  assign sel_srst  = |(soft_reset & port_onehot(addr_q));

`ifdef ROUTER_FSM_TIMEOUT_EN
  router_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .resetn  (resetn),
    .en      (st == WAIT_TILL_EMPTY),
    .expired (wait_expired)
  );
`else
  assign wait_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st     <= DECODE_ADDRESS;
      addr_q <= 2'b00;
    end else begin
      st <= nxt;
      if (st == DECODE_ADDRESS && hdr_ok) begin
        addr_q <= data_in;
      end
    end
  end

  always_comb begin
    nxt = st;
    unique case (st)
      DECODE_ADDRESS: begin
        if (hdr_ok) begin
          nxt = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full) begin
          nxt = FIFO_FULL_STATE;
        end else if (!pkt_vld) begin
          nxt = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          nxt = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          nxt = DECODE_ADDRESS;
        end else if (low_pkt_vld) begin
          nxt = LOAD_PARITY;
        end else begin
          nxt = LOAD_DATA;
        end
      end
      LOAD_PARITY: nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (sel_empty) begin
          nxt = LOAD_FIRST_DATA;
        end else if (wait_expired) begin
          nxt = DROP;
        end
      end
      DROP: begin
        if (!pkt_vld) begin
          nxt = DECODE_ADDRESS;
        end
      end
      default: nxt = DECODE_ADDRESS;
    endcase
    if (st != DECODE_ADDRESS && sel_srst) begin
      nxt = DECODE_ADDRESS;
    end
  end

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic drop_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= (st != DROP) && (nxt == DROP);
    end
  end

  assign drop_pkt = drop_q;
`else
  assign drop_pkt = 1'b0;
`endif

  assign detect_add    = (st == DECODE_ADDRESS);
  assign lfd_state     = (st == LOAD_FIRST_DATA);
  assign ld_state      = (st == LOAD_DATA);
  assign laf_state     = (st == LOAD_AFTER_FULL);
  assign full_state    = (st == FIFO_FULL_STATE);
  assign rst_int_reg   = (st == CHECK_PARITY_ERROR);
  assign write_enb_reg = (st == LOAD_DATA)
                      || (st == LOAD_PARITY)
                      || (st == LOAD_AFTER_FULL);
  assign busy          = (st == LOAD_FIRST_DATA)
                      || (st == FIFO_FULL_STATE)
                      || (st == LOAD_AFTER_FULL)
                      || (st == LOAD_PARITY)
                      || (st == WAIT_TILL_EMPTY)
                      || (st == CHECK_PARITY_ERROR);
  assign dest_sel      = (st == DECODE_ADDRESS || st == DROP)
                       ? 3'b000 : port_onehot(addr_q);

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: vector table, corner sequences and random run
// against a packet-level reference model of the router controller.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_vld = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic       fifo_full = 1'b0;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] soft_reset = 3'b000;
  logic       parity_done = 1'b0;
  logic       low_pkt_vld = 1'b0;

  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy, drop_pkt;
  logic [2:0] dest_sel;
  logic [11:0] dutv;

  localparam int LIM = 4;

  router_fsm #(.WAIT_LIMIT(LIM)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pkt_vld       (pkt_vld),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .soft_reset    (soft_reset),
    .parity_done   (parity_done),
    .low_pkt_vld   (low_pkt_vld),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .busy          (busy),
    .dest_sel      (dest_sel),
    .drop_pkt      (drop_pkt)
  );

  always #5 clk = ~clk;

  assign dutv = {detect_add, lfd_state, ld_state, laf_state, full_state,
                 rst_int_reg, write_enb_reg, busy, dest_sel, drop_pkt};

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum int {
    M_IDLE, M_FIRST, M_BODY, M_PAR, M_FULL, M_AFTER, M_WAIT, M_CHK, M_DROP
  } mph_t;

  mph_t mph = M_IDLE;
  int   maddr = 0;
  int   mwait = 0;
  bit   mdrop = 1'b0;

  function automatic logic [11:0] expv(mph_t p, logic [2:0] ds, bit d);
    return {p == M_IDLE, p == M_FIRST, p == M_BODY, p == M_AFTER,
            p == M_FULL, p == M_CHK,
            p == M_BODY || p == M_PAR || p == M_AFTER,
            p == M_FIRST || p == M_FULL || p == M_AFTER ||
            p == M_PAR || p == M_WAIT || p == M_CHK,
            ds, d};
  endfunction

  function automatic logic [11:0] mexp();
    logic [2:0] ds;
    ds = (mph == M_IDLE || mph == M_DROP) ? 3'b000 : 3'(1 << maddr);
    return expv(mph, ds, mdrop);
  endfunction

  task automatic model_reset();
    mph = M_IDLE;
    maddr = 0;
    mwait = 0;
    mdrop = 1'b0;
  endtask

  task automatic model_step();
    mdrop = 1'b0;
    if (mph != M_IDLE && soft_reset[maddr]) begin
      mph = M_IDLE;
      return;
    end
    case (mph)
      M_IDLE: if (pkt_vld && data_in != 2'b11) begin
        maddr = int'(data_in);
        mwait = 0;
        mph = fifo_empty[maddr] ? M_FIRST : M_WAIT;
      end
      M_FIRST: mph = M_BODY;
      M_BODY: begin
        if (fifo_full) mph = M_FULL;
        else if (!pkt_vld) mph = M_PAR;
      end
      M_FULL: if (!fifo_full) mph = M_AFTER;
      M_AFTER: begin
        if (parity_done) mph = M_IDLE;
        else if (low_pkt_vld) mph = M_PAR;
        else mph = M_BODY;
      end
      M_PAR: mph = M_CHK;
      M_CHK: mph = fifo_full ? M_FULL : M_IDLE;
      M_WAIT: begin
        mwait++;
        if (fifo_empty[maddr]) mph = M_FIRST;
`ifdef ROUTER_FSM_TIMEOUT_EN
        else if (mwait == LIM) begin
          mph = M_DROP;
          mdrop = 1'b1;
        end
`endif
      end
      M_DROP: if (!pkt_vld) mph = M_IDLE;
      default: mph = M_IDLE;
    endcase
  endtask

  task automatic check(string name, logic [11:0] exp);
    n_tests++;
    if (dutv !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, dutv, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(logic pv, logic [1:0] din, logic ff,
                       logic [2:0] fe, logic [2:0] sr,
                       logic pd, logic lpv);
    pkt_vld = pv;
    data_in = din;
    fifo_full = ff;
    fifo_empty = fe;
    soft_reset = sr;
    parity_done = pd;
    low_pkt_vld = lpv;
  endtask

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] fe;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    mph_t       ph;
    logic [2:0] ds;
  } vec_t;

  vec_t tbl[$];

  task automatic row(logic pv, logic [1:0] din, logic ff, logic [2:0] fe,
                     logic [2:0] sr, logic pd, logic lpv,
                     mph_t ph, logic [2:0] ds);
    vec_t v;
    v = '{pv, din, ff, fe, sr, pd, lpv, ph, ds};
    tbl.push_back(v);
  endtask

  initial begin
    row(1, 2'b01, 0, 3'b111, 3'b000, 0, 0, M_FIRST, 3'b010);
    row(1, 2'b11, 0, 3'b111, 3'b000, 0, 0, M_BODY,  3'b010);
    row(1, 2'b11, 0, 3'b111, 3'b000, 0, 0, M_BODY,  3'b010);
    row(1, 2'b11, 0, 3'b111, 3'b000, 0, 0, M_BODY,  3'b010);
    row(0, 2'b11, 0, 3'b111, 3'b000, 0, 0, M_PAR,   3'b010);
    row(0, 2'b11, 0, 3'b111, 3'b000, 0, 0, M_CHK,   3'b010);
    row(0, 2'b11, 0, 3'b111, 3'b000, 0, 0, M_IDLE,  3'b000);
    row(1, 2'b10, 0, 3'b011, 3'b000, 0, 0, M_WAIT,  3'b100);
    row(1, 2'b00, 0, 3'b011, 3'b000, 0, 0, M_WAIT,  3'b100);
    row(1, 2'b00, 0, 3'b011, 3'b000, 0, 0, M_WAIT,  3'b100);
    row(1, 2'b00, 0, 3'b011, 3'b000, 0, 0, M_WAIT,  3'b100);
    row(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, M_FIRST, 3'b100);
    row(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, M_BODY,  3'b100);
    row(1, 2'b00, 1, 3'b111, 3'b000, 0, 1, M_FULL,  3'b100);
    row(1, 2'b00, 1, 3'b111, 3'b000, 0, 1, M_FULL,  3'b100);
    row(1, 2'b00, 1, 3'b111, 3'b000, 0, 1, M_FULL,  3'b100);
    row(1, 2'b00, 0, 3'b111, 3'b000, 0, 1, M_AFTER, 3'b100);
    row(1, 2'b00, 0, 3'b111, 3'b000, 0, 1, M_PAR,   3'b100);
    row(0, 2'b00, 0, 3'b111, 3'b000, 0, 0, M_CHK,   3'b100);
    row(0, 2'b00, 0, 3'b111, 3'b000, 0, 0, M_IDLE,  3'b000);
    row(1, 2'b11, 0, 3'b111, 3'b000, 0, 0, M_IDLE,  3'b000);
    row(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, M_FIRST, 3'b001);
    row(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, M_BODY,  3'b001);
    row(1, 2'b00, 0, 3'b111, 3'b010, 0, 0, M_BODY,  3'b001);
    row(1, 2'b00, 0, 3'b111, 3'b001, 0, 0, M_IDLE,  3'b000);
    row(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, M_FIRST, 3'b001);
    row(1, 2'b00, 0, 3'b111, 3'b000, 0, 0, M_BODY,  3'b001);
    row(0, 2'b00, 1, 3'b111, 3'b000, 0, 0, M_FULL,  3'b001);
    row(0, 2'b00, 0, 3'b111, 3'b000, 0, 0, M_AFTER, 3'b001);
    row(0, 2'b00, 0, 3'b111, 3'b000, 1, 0, M_IDLE,  3'b000);
    row(1, 2'b01, 0, 3'b101, 3'b000, 0, 0, M_WAIT,  3'b010);
    row(1, 2'b01, 0, 3'b111, 3'b010, 0, 0, M_IDLE,  3'b000);
    row(1, 2'b10, 0, 3'b111, 3'b000, 0, 0, M_FIRST, 3'b100);
    row(1, 2'b10, 0, 3'b111, 3'b000, 0, 0, M_BODY,  3'b100);
    row(0, 2'b10, 0, 3'b111, 3'b000, 0, 0, M_PAR,   3'b100);
    row(0, 2'b10, 1, 3'b111, 3'b000, 0, 0, M_CHK,   3'b100);
    row(0, 2'b10, 1, 3'b111, 3'b000, 0, 0, M_FULL,  3'b100);
    row(0, 2'b10, 0, 3'b111, 3'b000, 0, 0, M_AFTER, 3'b100);
    row(0, 2'b10, 0, 3'b111, 3'b000, 0, 0, M_BODY,  3'b100);
    row(0, 2'b10, 0, 3'b111, 3'b000, 0, 0, M_PAR,   3'b100);
    row(0, 2'b10, 0, 3'b111, 3'b000, 0, 0, M_CHK,   3'b100);
    row(0, 2'b10, 0, 3'b111, 3'b000, 0, 0, M_IDLE,  3'b000);

    #1;
    check("reset_state", expv(M_IDLE, 3'b000, 1'b0));
    @(negedge clk);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].pv, tbl[i].din, tbl[i].ff, tbl[i].fe,
            tbl[i].sr, tbl[i].pd, tbl[i].lpv);
      tick();
      check($sformatf("vec%0d", i), expv(tbl[i].ph, tbl[i].ds, 1'b0));
    end

    @(negedge clk);
    drive(1, 2'b01, 0, 3'b111, 3'b000, 0, 0);
    tick();
    @(negedge clk);
    tick();
    check("pre_reset_ld", expv(M_BODY, 3'b010, 1'b0));
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check("async_reset", expv(M_IDLE, 3'b000, 1'b0));
    @(posedge clk);
    #1;
    check("held_reset", expv(M_IDLE, 3'b000, 1'b0));
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 2'b00, 0, 3'b111, 3'b000, 0, 0);

`ifdef ROUTER_FSM_TIMEOUT_EN
    @(negedge clk);
    drive(1, 2'b01, 0, 3'b000, 3'b000, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("wte%0d", k), expv(M_WAIT, 3'b010, 1'b0));
      @(negedge clk);
    end
    tick();
    check("drop_entry", expv(M_DROP, 3'b000, 1'b1));
    @(negedge clk);
    tick();
    check("drop_hold", expv(M_DROP, 3'b000, 1'b0));
    @(negedge clk);
    pkt_vld = 1'b0;
    tick();
    check("drop_exit", expv(M_IDLE, 3'b000, 1'b0));
`endif

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      pkt_vld = ($urandom_range(0, 4) != 0);
      data_in = 2'($urandom_range(0, 3));
      fifo_full = ($urandom_range(0, 4) == 0);
      fifo_empty = 3'($urandom_range(0, 7));
      soft_reset = {($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 19) == 0)};
      parity_done = ($urandom_range(0, 2) == 0);
      low_pkt_vld = ($urandom_range(0, 1) == 0);
      tick();
      check($sformatf("rand%0d", n), mexp());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
